// File: rtl/sfifo_pkg.sv
// Shared defaults for the synchronous FIFO.
package sfifo_pkg;

    localparam int unsigned SFIFO_WIDTH_DFLT = 8;
    localparam int unsigned SFIFO_DEPTH_DFLT = 2;

endpackage : sfifo_pkg

// File: rtl/sfifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Circular buffer of 2^DEPTH words; one slot stays unused, so capacity is 2^DEPTH-1.
module sfifo
    import sfifo_pkg::*;
#(
    parameter int unsigned WIDTH = SFIFO_WIDTH_DFLT,
    parameter int unsigned DEPTH = SFIFO_DEPTH_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             store,
    input  logic             read,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned ENTRIES = 1 << DEPTH;

    // Storage has no reset so it can map onto distributed RAM.
    logic [WIDTH-1:0] buffer [ENTRIES];

    logic [DEPTH-1:0] rpos_q, rpos_d;
    logic [DEPTH-1:0] wpos_q, wpos_d;
    logic [DEPTH-1:0] rpos, wpos;
    logic [DEPTH-1:0] wpos_inc, rpos_inc;
    logic             wr_en, rd_en;

    assign rpos = rpos_q;
    assign wpos = wpos_q;

    always_comb begin
        rpos_inc = rpos_q + DEPTH'(1);
        wpos_inc = wpos_q + DEPTH'(1);
        empty    = (rpos_q == wpos_q);
        full     = (wpos_inc == rpos_q);
        wr_en    = store && !full;
        rd_en    = read && !empty;
        rpos_d   = rd_en ? rpos_inc : rpos_q;
        wpos_d   = wr_en ? wpos_inc : wpos_q;
        rdata    = buffer[rpos_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpos_q <= '0;
            wpos_q <= '0;
        end else begin
            rpos_q <= rpos_d;
            wpos_q <= wpos_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buffer[wpos_q] <= wdata;
        end
    end

endmodule : sfifo

// File: tb/tb_sfifo.sv
// Directed-vector bench for sfifo at WIDTH=8, DEPTH=2.
module tb_sfifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       store;
    logic       read;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       empty;
    logic       full;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    sfifo #(.WIDTH(8), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .store (store),
        .read  (read),
        .wdata (wdata),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        store = 1'b1;
        wdata = d;
        tick();
        store = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        read = 1'b1;
        #1;
        check(tag, 32'(rdata), 32'(exp));
        tick();
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        store = 1'b0;
        read  = 1'b0;
        wdata = '0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_rpos",  32'(dut.rpos), 32'd0);
        check("rst_wpos",  32'(dut.wpos), 32'd0);

        // Read while empty is ignored
        read = 1'b1;
        tick();
        read = 1'b0;
        check("uflow_rpos",  32'(dut.rpos), 32'd0);
        check("uflow_empty", 32'(empty), 32'd1);

        push(8'h12);
        check("p1_empty", 32'(empty), 32'd0);
        check("p1_wpos",  32'(dut.wpos), 32'd1);
        check("p1_buf0",  32'(dut.buffer[0]), 32'h12);
        check("p1_rdata", 32'(rdata), 32'h12);

        push(8'h34);
        check("p2_full", 32'(full), 32'd0);
        push(8'h56);
        check("p3_full", 32'(full), 32'd1);
        check("p3_wpos", 32'(dut.wpos), 32'd3);
        check("p3_rpos", 32'(dut.rpos), 32'd0);

        push(8'hee);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_wpos", 32'(dut.wpos), 32'd3);
        check("ovf_rpos", 32'(dut.rpos), 32'd0);
        check("ovf_buf2", 32'(dut.buffer[2]), 32'h56);
        check("ovf_rdata", 32'(rdata), 32'h12);

        pop("pop1", 8'h12);
        pop("pop2", 8'h34);
        check("pop2_full", 32'(full), 32'd0);
        pop("pop3", 8'h56);
        check("pop3_empty", 32'(empty), 32'd1);
        check("pop3_rpos",  32'(dut.rpos), 32'd3);
        check("pop3_wpos",  32'(dut.wpos), 32'd3);

        push(8'h78);
        check("wrap_buf3", 32'(dut.buffer[3]), 32'h78);
        check("wrap_wpos", 32'(dut.wpos), 32'd0);

        store = 1'b1;
        wdata = 8'h9a;
        pop("simul_pop", 8'h78);
        store = 1'b0;
        check("simul_rpos",  32'(dut.rpos), 32'd0);
        check("simul_wpos",  32'(dut.wpos), 32'd1);
        check("simul_buf0",  32'(dut.buffer[0]), 32'h9a);
        check("simul_empty", 32'(empty), 32'd0);
        check("simul_full",  32'(full), 32'd0);

        pop("pop9a", 8'h9a);
        push(8'hbc);
        push(8'hde);
        push(8'hf0);
        check("wfill_full", 32'(full), 32'd1);
        check("wfill_rpos", 32'(dut.rpos), 32'd1);
        check("wfill_wpos", 32'(dut.wpos), 32'd0);
        check("wfill_rdata", 32'(rdata), 32'hbc);

        // Reset wins over concurrent read and store
        reset = 1'b1;
        read  = 1'b1;
        store = 1'b1;
        wdata = 8'h11;
        tick();
        reset = 1'b0;
        read  = 1'b0;
        store = 1'b0;
        check("rst2_empty", 32'(empty), 32'd1);
        check("rst2_full",  32'(full), 32'd0);
        check("rst2_rpos",  32'(dut.rpos), 32'd0);
        check("rst2_wpos",  32'(dut.wpos), 32'd0);
        check("rst2_buf0",  32'(dut.buffer[0]), 32'h9a);
        check("rst2_buf1",  32'(dut.buffer[1]), 32'hbc);
        check("rst2_buf2",  32'(dut.buffer[2]), 32'hde);
        check("rst2_buf3",  32'(dut.buffer[3]), 32'hf0);

        push(8'h21);
        check("post_rdata", 32'(rdata), 32'h21);
        check("post_wpos",  32'(dut.wpos), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_sfifo
